vector_adder_sequencer: RTL

- Sequences one vector add/sub instruction over a segmented byte-slice adder, one element group per beat.
- Parametrised successor to the fixed 8-slice multiplexer control unit:
  - slice count is generic;
  - request/issue handshakes are added;
  - an element counter and tail masking against vl are added.
- Sits between the vector issue stage and the slice-adder datapath. Per beat it drives per-slice carry-select codes and slice enables.

---
 rtl/vector_adder_sequencer_pkg.sv | 38 +++
 rtl/vector_adder_sequencer_if.sv | 39 +++
 rtl/vector_adder_sequencer_slice_select_decoder.sv | 57 +++++
 rtl/vector_adder_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vector_adder_sequencer_pkg.sv
// Shared definitions for the vector add/sub sequencer.
//   - Carry-in select codes driven to each 8-bit adder slice.
//   - Element-width (sew) encodings.
//   - Sequencer FSM state type.
//   - head_code(): maps the instruction's op bits to the code used by the
//     least-significant slice of every element.
package vector_adder_pkg;

  localparam logic [1:0] SEL_INTERCONNECT = 2'b00;  // carry from slice i-1
  localparam logic [1:0] SEL_ADD          = 2'b01;  // cin = 0
  localparam logic [1:0] SEL_SUB          = 2'b10;  // cin = 1, B inverted
  localparam logic [1:0] SEL_EXT_CARRY    = 2'b11;  // external carry/borrow

  localparam logic [1:0] SEW_8  = 2'd0;
  localparam logic [1:0] SEW_16 = 2'd1;
  localparam logic [1:0] SEW_32 = 2'd2;
  localparam logic [1:0] SEW_64 = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } seq_state_e;

  // vadc/vsbc use the external carry whatever the add/sub bit says.
  function automatic logic [1:0] head_code(input logic add_sub,
                                           input logic with_carry_borrow);
    logic [1:0] code;
    if (with_carry_borrow) begin
      code = SEL_EXT_CARRY;
    end else if (add_sub) begin
      code = SEL_SUB;
    end else begin
      code = SEL_ADD;
    end
    return code;
  endfunction

endpackage

// File: rtl/vector_adder_sequencer_if.sv
// Request/issue bus between the vector issue stage, the sequencer and the
// slice-adder datapath. Signal names keep the sequencer's point of view
// (_i = into the sequencer, _o = out of it).
//   slave  : the sequencer side
//   master : the issue-stage / datapath side
interface vector_adder_sequencer_if #(
  parameter int NUM_SLICES = 8,
  parameter int VL_WIDTH   = 11
);

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    add_sub_i;
  logic                    with_carry_borrow_i;
  logic [1:0]              vsew_i;
  logic [VL_WIDTH-1:0]     vl_i;
  logic                    issue_valid_o;
  logic                    issue_ready_i;
  logic [2*NUM_SLICES-1:0] slice_sel_o;
  logic [NUM_SLICES-1:0]   slice_en_o;
  logic [VL_WIDTH-1:0]     elem_base_o;
  logic                    last_o;
  logic                    busy_o;

  modport slave (
    input  req_valid_i, add_sub_i, with_carry_borrow_i, vsew_i, vl_i,
           issue_ready_i,
    output req_ready_o, issue_valid_o, slice_sel_o, slice_en_o,
           elem_base_o, last_o, busy_o
  );

  modport master (
    output req_valid_i, add_sub_i, with_carry_borrow_i, vsew_i, vl_i,
           issue_ready_i,
    input  req_ready_o, issue_valid_o, slice_sel_o, slice_en_o,
           elem_base_o, last_o, busy_o
  );

endinterface

// File: rtl/vector_adder_sequencer_slice_select_decoder.sv
// Combinational per-beat decoder for the segmented slice adder.
//   head_code_i : code given to the first slice of each element
//   sew_i       : element width (slices per element = 2^sew)
//   elem_base_i : index of the first element covered by this beat
//   vl_i        : vector length; elements at or beyond vl are masked off
//   slice_sel_o : per-slice carry-in select, slice i at [2i+1:2i]
//   slice_en_o  : per-slice write enable
module slice_select_decoder
  import vector_adder_pkg::*;
#(
  parameter int NUM_SLICES = 8,
  parameter int VL_WIDTH   = 11
) (
  input  logic [1:0]              head_code_i,
  input  logic [1:0]              sew_i,
  input  logic [VL_WIDTH-1:0]     elem_base_i,
  input  logic [VL_WIDTH-1:0]     vl_i,
  output logic [2*NUM_SLICES-1:0] slice_sel_o,
  output logic [NUM_SLICES-1:0]   slice_en_o
);

  logic [3:0]          lane_mask_s;  // 2^sew - 1: low bits of slice index within an element
  logic [VL_WIDTH:0]   elem_idx_s;   // one spare bit so base + offset cannot wrap

  // Slice-within-element mask for the current element width.
  always_comb begin
    case (sew_i)
      SEW_8:   lane_mask_s = 4'd0;
      SEW_16:  lane_mask_s = 4'd1;
      SEW_32:  lane_mask_s = 4'd3;
      SEW_64:  lane_mask_s = 4'd7;
      default: lane_mask_s = 4'd0;
    endcase
  end

  // Per-slice enable from the tail mask and head/interconnect select.
  always_comb begin
    slice_sel_o = '0;
    slice_en_o  = '0;
    elem_idx_s  = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      elem_idx_s = {1'b0, elem_base_i} + (VL_WIDTH+1)'(i >> sew_i);
      if (elem_idx_s < {1'b0, vl_i}) begin
        slice_en_o[i] = 1'b1;
        if ((i[3:0] & lane_mask_s) == 4'd0) begin
          slice_sel_o[2*i +: 2] = head_code_i;
        end else begin
          slice_sel_o[2*i +: 2] = SEL_INTERCONNECT;
        end
      end else begin
        slice_en_o[i]         = 1'b0;
        slice_sel_o[2*i +: 2] = SEL_INTERCONNECT;
      end
    end
  end

endmodule

// File: rtl/vector_adder_sequencer.sv
// Sequences one vector add/sub instruction over NUM_SLICES byte slices,
// one element group per beat, with tail masking against vl.
//   clk_i  : clock
//   rstn_i : synchronous active-low reset
//   bus    : request handshake (op, vsew, vl) in; per-beat slice selects,
//            enables, elem_base, last, busy out with issue handshake.
// All outputs come straight from flops; the next beat is decoded one cycle
// ahead so it is visible the cycle after the accepting/consuming edge.
module vector_adder_sequencer
  import vector_adder_pkg::*;
#(
  parameter int NUM_SLICES = 8,
  parameter int VL_WIDTH   = 11
) (
  input logic                    clk_i,
  input logic                    rstn_i,
  vector_adder_sequencer_if.slave bus
);

  seq_state_e              state_q, state_d;
  logic [1:0]              head_q, head_d;
  logic [1:0]              sew_q, sew_d;
  logic [VL_WIDTH-1:0]     vl_q, vl_d;
  logic [VL_WIDTH-1:0]     elem_base_q, elem_base_d;
  logic [VL_WIDTH-1:0]     remaining_q, remaining_d;
  logic                    req_ready_q, req_ready_d;
  logic                    issue_valid_q, issue_valid_d;
  logic                    busy_q, busy_d;
  logic                    last_q, last_d;
  logic [2*NUM_SLICES-1:0] slice_sel_q, slice_sel_d;
  logic [NUM_SLICES-1:0]   slice_en_q, slice_en_d;

  logic [1:0]              dec_head_s;
  logic [1:0]              dec_sew_s;
  logic [VL_WIDTH-1:0]     dec_vl_s;
  logic [VL_WIDTH-1:0]     dec_base_s;
  logic [2*NUM_SLICES-1:0] dec_sel_s;
  logic [NUM_SLICES-1:0]   dec_en_s;

  function automatic logic [VL_WIDTH-1:0] elems_per_beat(input logic [1:0] sew);
    logic [VL_WIDTH-1:0] slices;
    slices = VL_WIDTH'(NUM_SLICES);
    return slices >> sew;
  endfunction

  // Operands of the beat that would be issued next: a fresh instruction
  // from the bus while idle, otherwise the following group of the current one.
  always_comb begin
    if (state_q == ST_IDLE) begin
      dec_head_s = head_code(bus.add_sub_i, bus.with_carry_borrow_i);
      dec_sew_s  = bus.vsew_i;
      dec_vl_s   = bus.vl_i;
      dec_base_s = '0;
    end else begin
      dec_head_s = head_q;
      dec_sew_s  = sew_q;
      dec_vl_s   = vl_q;
      dec_base_s = elem_base_q + elems_per_beat(sew_q);
    end
  end

  slice_select_decoder #(
    .NUM_SLICES (NUM_SLICES),
    .VL_WIDTH   (VL_WIDTH)
  ) u_decoder (
    .head_code_i (dec_head_s),
    .sew_i       (dec_sew_s),
    .elem_base_i (dec_base_s),
    .vl_i        (dec_vl_s),
    .slice_sel_o (dec_sel_s),
    .slice_en_o  (dec_en_s)
  );

  // FSM next state, counters and next registered outputs.
  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    sew_d         = sew_q;
    vl_d          = vl_q;
    elem_base_d   = elem_base_q;
    remaining_d   = remaining_q;
    req_ready_d   = req_ready_q;
    issue_valid_d = issue_valid_q;
    busy_d        = busy_q;
    last_d        = last_q;
    slice_sel_d   = slice_sel_q;
    slice_en_d    = slice_en_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i && (bus.vl_i != '0)) begin
          state_d       = ST_ISSUE;
          head_d        = dec_head_s;
          sew_d         = bus.vsew_i;
          vl_d          = bus.vl_i;
          elem_base_d   = '0;
          remaining_d   = bus.vl_i;
          req_ready_d   = 1'b0;
          issue_valid_d = 1'b1;
          busy_d        = 1'b1;
          last_d        = (bus.vl_i <= elems_per_beat(bus.vsew_i));
          slice_sel_d   = dec_sel_s;
          slice_en_d    = dec_en_s;
        end else begin
          // A vl == 0 request still handshakes here but issues nothing.
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus.issue_ready_i) begin
          if (last_q) begin
            state_d       = ST_IDLE;
            elem_base_d   = '0;
            remaining_d   = '0;
            req_ready_d   = 1'b1;
            issue_valid_d = 1'b0;
            busy_d        = 1'b0;
            last_d        = 1'b0;
            slice_sel_d   = '0;
            slice_en_d    = '0;
          end else begin
            elem_base_d = dec_base_s;
            remaining_d = remaining_q - elems_per_beat(sew_q);
            last_d      = (remaining_d <= elems_per_beat(sew_q));
            slice_sel_d = dec_sel_s;
            slice_en_d  = dec_en_s;
          end
        end else begin
          // Stalled: every flop holds.
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        elem_base_d   = '0;
        remaining_d   = '0;
        req_ready_d   = 1'b1;
        issue_valid_d = 1'b0;
        busy_d        = 1'b0;
        last_d        = 1'b0;
        slice_sel_d   = '0;
        slice_en_d    = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      head_q        <= 2'b00;
      sew_q         <= 2'b00;
      vl_q          <= '0;
      elem_base_q   <= '0;
      remaining_q   <= '0;
      req_ready_q   <= 1'b1;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      last_q        <= 1'b0;
      slice_sel_q   <= '0;
      slice_en_q    <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      sew_q         <= sew_d;
      vl_q          <= vl_d;
      elem_base_q   <= elem_base_d;
      remaining_q   <= remaining_d;
      req_ready_q   <= req_ready_d;
      issue_valid_q <= issue_valid_d;
      busy_q        <= busy_d;
      last_q        <= last_d;
      slice_sel_q   <= slice_sel_d;
      slice_en_q    <= slice_en_d;
    end
  end

  assign bus.req_ready_o   = req_ready_q;
  assign bus.issue_valid_o = issue_valid_q;
  assign bus.busy_o        = busy_q;
  assign bus.last_o        = last_q;
  assign bus.slice_sel_o   = slice_sel_q;
  assign bus.slice_en_o    = slice_en_q;
  assign bus.elem_base_o   = elem_base_q;

endmodule
